// File: rtl/three_input_debouncer.sv
// three_input_debouncer: three independent switch debouncers feeding the
// downstream three-input AND stage. Each channel has a 2-flop synchronizer and
// a stability counter. The output follows the synchronized level only after
// that level has differed from the output for STABLE_CYCLES consecutive clocks.
// Optional feature macro: THREE_AND_OUT_EN adds registered o_d = a&b and
// o_e = a&b&c, each one clock behind the debounced outputs.

// One debounce channel: synchronizer, stability counter, registered level and strobe.
module three_input_debouncer_ch #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_q,
    output logic o_chg
);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(STABLE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_q;
    logic             r_chg;

    // Synchronize, then count consecutive clocks where s2 disagrees with q.
    // The counter clears when s2 agrees again, so a short glitch never reaches q,
    // and it tops out at TERM, so it cannot wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_cnt <= '0;
            r_q   <= 1'b0;
            r_chg <= 1'b0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            if (r_s2 == r_q) begin
                r_cnt <= '0;
                r_chg <= 1'b0;
            end else if (r_cnt == TERM) begin
                r_q   <= r_s2;
                r_cnt <= '0;
                r_chg <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
                r_chg <= 1'b0;
            end
        end
    end

    assign o_q   = r_q;
    assign o_chg = r_chg;
endmodule

module three_input_debouncer #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_a_raw,
    input  logic       i_b_raw,
    input  logic       i_c_raw,
    output logic       o_a,
    output logic       o_b,
    output logic       o_c,
    output logic [2:0] o_chg
`ifdef THREE_AND_OUT_EN
    ,
    output logic       o_d,
    output logic       o_e
`endif
);
    localparam int NUM_CH = 3;

    // A count of zero or one beyond the counter range can never be reached.
    if (STABLE_CYCLES < 1 ||
        longint'(STABLE_CYCLES) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_param
        $error("three_input_debouncer: STABLE_CYCLES=%0d outside 1..2**CNT_W-1", STABLE_CYCLES);
    end

    logic [NUM_CH-1:0] w_raw;
    logic [NUM_CH-1:0] w_q;
    logic [NUM_CH-1:0] w_chg;

    assign w_raw = {i_c_raw, i_b_raw, i_a_raw};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        three_input_debouncer_ch #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .CNT_W        (CNT_W)
        ) u_ch (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_raw (w_raw[g]),
            .o_q   (w_q[g]),
            .o_chg (w_chg[g])
        );
    end

    assign o_a   = w_q[0];
    assign o_b   = w_q[1];
    assign o_c   = w_q[2];
    assign o_chg = w_chg;

`ifdef THREE_AND_OUT_EN
    logic r_d;
    logic r_e;

    // AND terms taken from the registered debounced levels, one clock behind them.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_d <= 1'b0;
            r_e <= 1'b0;
        end else begin
            r_d <= w_q[0] & w_q[1];
            r_e <= &w_q;
        end
    end

    assign o_d = r_d;
    assign o_e = r_e;
`endif
endmodule

// File: tb/tb_three_input_debouncer.sv
// Bench for three_input_debouncer: directed scenarios followed by random
// stimulus. Every edge is checked against a reference model built from a
// history of synchronized levels: a channel flips when the last STABLE_CYCLES
// synchronized samples all oppose its output and no flip or reset has occurred
// within that window.
module tb_three_input_debouncer;
    localparam int S    = 4;
    localparam int MAXE = 4096;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_raw, b_raw, c_raw;
    logic       a, b, c;
    logic [2:0] chg;
`ifdef THREE_AND_OUT_EN
    logic       d, e;
`endif

    always #5 clk = ~clk;

    three_input_debouncer #(.STABLE_CYCLES(S), .CNT_W(16)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_a_raw (a_raw),
        .i_b_raw (b_raw),
        .i_c_raw (c_raw),
        .o_a     (a),
        .o_b     (b),
        .o_c     (c),
        .o_chg   (chg)
`ifdef THREE_AND_OUT_EN
        ,
        .o_d     (d),
        .o_e     (e)
`endif
    );

    int checks = 0;
    int errors = 0;
    int n      = 0;

    // s1h[k]: first-stage level after edge k; syn[k]: synchronized level after edge k
    logic [2:0] s1h [0:MAXE];
    logic [2:0] syn [0:MAXE];
    logic [2:0] mq, mchg;
    logic       md, me;
    int         last_ev [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, exp, n);
        end
    endtask

    task automatic model_edge(input logic r, input logic [2:0] raw);
        logic [2:0] oldq;
        logic       all;
        oldq = mq;
        n++;
        if (n >= MAXE) begin
            $display("FAIL model_capacity edge=%0d limit=%0d", n, MAXE);
            $fatal(1, "model history exhausted");
        end
        mchg = 3'b000;
        if (r) begin
            s1h[n] = 3'b000;
            syn[n] = 3'b000;
            mq = 3'b000;
            md = 1'b0;
            me = 1'b0;
            for (int ch = 0; ch < 3; ch++) last_ev[ch] = n;
        end else begin
            s1h[n] = raw;
            syn[n] = s1h[n-1];
            for (int ch = 0; ch < 3; ch++) begin
                if (n - last_ev[ch] >= S && n - S >= 1) begin
                    all = 1'b1;
                    for (int k = n - S; k <= n - 1; k++)
                        if (syn[k][ch] == oldq[ch]) all = 1'b0;
                    if (all) begin
                        mq[ch]      = ~oldq[ch];
                        mchg[ch]    = 1'b1;
                        last_ev[ch] = n;
                    end
                end
            end
            md = oldq[0] & oldq[1];
            me = &oldq;
        end
    endtask

    // Drive, clock once, update the model, then compare just after the edge.
    task automatic tick(input logic r, input logic [2:0] raw);
        rst = r;
        {c_raw, b_raw, a_raw} = raw;
        @(posedge clk);
        model_edge(r, raw);
        #1;
        chk("q", {29'd0, c, b, a}, {29'd0, mq});
        chk("chg", {29'd0, chg}, {29'd0, mchg});
`ifdef THREE_AND_OUT_EN
        chk("d", {31'd0, d}, {31'd0, md});
        chk("e", {31'd0, e}, {31'd0, me});
`endif
    endtask

    task automatic hold(input logic [2:0] raw, input int cnt);
        for (int i = 0; i < cnt; i++) tick(1'b0, raw);
    endtask

    initial begin
        int kb, pulses, ka, kc;
        logic [2:0] rv;
        int len;

        rst = 1'b1;
        {c_raw, b_raw, a_raw} = 3'b111;
        s1h[0] = 3'b000;
        syn[0] = 3'b000;
        mq = 3'b000; mchg = 3'b000; md = 1'b0; me = 1'b0;
        for (int ch = 0; ch < 3; ch++) last_ev[ch] = 0;

        // 1: reset held with raw high, then release
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 3'b111);
            chk("t1_rst_q", {29'd0, c, b, a}, 32'd0);
            chk("t1_rst_chg", {29'd0, chg}, 32'd0);
        end
        hold(3'b111, 5);
        chk("t1_edge5_q", {29'd0, c, b, a}, 32'd0);
        tick(1'b0, 3'b111);
        chk("t1_edge6_q", {29'd0, c, b, a}, 32'd7);
        chk("t1_edge6_chg", {29'd0, chg}, 32'd7);

        // 2: a falls, settles, then rises and is held
        hold(3'b110, 10);
        hold(3'b111, 5);
        chk("t2_edge5_a", {31'd0, a}, 32'd0);
        tick(1'b0, 3'b111);
        chk("t2_edge6_a", {31'd0, a}, 32'd1);
        chk("t2_edge6_chg", {29'd0, chg}, 32'd1);
        tick(1'b0, 3'b111);
        chk("t2_edge7_chg", {29'd0, chg}, 32'd0);

        // 3: b falls, then bounces 1,1,0 before a held rise
        hold(3'b101, 10);
        tick(1'b0, 3'b111);
        tick(1'b0, 3'b111);
        tick(1'b0, 3'b101);
        kb = 0; pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            tick(1'b0, 3'b111);
            if (chg[1]) pulses++;
            if (b && kb == 0) kb = k;
        end
        chk("t3_rise_edge", kb, 32'd6);
        chk("t3_pulses", pulses, 32'd1);

        // 4: all channels rise together, later fall together
        hold(3'b000, 10);
        ka = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(1'b0, 3'b111);
            if (chg != 3'b000 && ka == 0) begin
                ka = k;
                chk("t4_rise_chg", {29'd0, chg}, 32'd7);
            end
        end
        chk("t4_rise_edge", ka, 32'd6);
        ka = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(1'b0, 3'b000);
            if (chg != 3'b000 && ka == 0) begin
                ka = k;
                chk("t4_fall_chg", {29'd0, chg}, 32'd7);
            end
        end
        chk("t4_fall_edge", ka, 32'd6);

        // 5: c rises, reset lands while its count is at 2
        hold(3'b100, 4);
        tick(1'b1, 3'b100);
        chk("t5_rst_c", {31'd0, c}, 32'd0);
        kc = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(1'b0, 3'b100);
            if (c && kc == 0) kc = k;
        end
        chk("t5_rise_edge", kc, 32'd6);

`ifdef THREE_AND_OUT_EN
        // 6: a=b=1, c=0, then c rises; e follows c by one clock
        hold(3'b011, 12);
        chk("t6_d", {31'd0, d}, 32'd1);
        chk("t6_e", {31'd0, e}, 32'd0);
        kc = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(1'b0, 3'b111);
            if (c && kc == 0) begin
                kc = k;
                chk("t6_e_same_edge", {31'd0, e}, 32'd0);
                tick(1'b0, 3'b111);
                chk("t6_e_next_edge", {31'd0, e}, 32'd1);
            end
        end
        chk("t6_c_edge", kc, 32'd6);
`endif

        // random: segments of random levels and hold lengths, occasional reset
        for (int sgm = 0; sgm < 120; sgm++) begin
            rv  = 3'($urandom_range(0, 7));
            len = $urandom_range(1, 8);
            if ($urandom_range(0, 25) == 0) tick(1'b1, rv);
            hold(rv, len);
        end
        hold(3'b000, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout edge=%0d limit=200000ns", n);
        $fatal(1, "timeout");
    end
endmodule
